// File: rtl/input_sampler_pkg.sv
// Shared types and defaults for the input_sampler debounce/qualifier block.
package input_sampler_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam int DEF_WIDTH        = 8;
  localparam int DEF_STABLE_COUNT = 4;
  localparam int CNT_W            = 8;

endpackage

// File: rtl/input_sampler_sync_2ff.sv
// Per-bit two-flop synchroniser for raw_in; only built when INPUT_SAMPLER_SYNC_EN is defined.
module sync_2ff #(
  parameter int WIDTH = 8
) (
  input  logic             n_clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_d, meta_q;
  logic [WIDTH-1:0] sync_d, sync_q;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge n_clock) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/input_sampler.sv
// Qualifies raw_in on clk_read ticks and hands stable words to a consumer with valid/ack.
// Optional input synchroniser enabled by defining INPUT_SAMPLER_SYNC_EN.
//
//   state | meaning
//   IDLE  | no unacknowledged word; report the next stable word that differs from data_out
//   HOLD  | data_out/data_valid frozen until data_ack; new stable words flag overrun
module input_sampler
  import input_sampler_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int STABLE_COUNT = DEF_STABLE_COUNT
) (
  input  logic             n_clock,
  input  logic             reset,
  input  logic             clk_read,
  input  logic [WIDTH-1:0] raw_in,
  input  logic             data_ack,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             overrun
);

  localparam logic [CNT_W-1:0] STABLE_CNT = CNT_W'(STABLE_COUNT);

  logic [WIDTH-1:0] sample;

`ifdef INPUT_SAMPLER_SYNC_EN
  sync_2ff #(.WIDTH(WIDTH)) u_sync (
    .n_clock (n_clock),
    .reset   (reset),
    .d       (raw_in),
    .q       (sample)
  );
`else
  assign sample = raw_in;
`endif

  state_e           state_d, state_q;
  logic [WIDTH-1:0] cand_d, cand_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [WIDTH-1:0] data_out_d, data_out_q;
  logic             overrun_d, overrun_q;
  logic             word_ready;

  always_comb begin
    cand_d     = cand_q;
    cnt_d      = cnt_q;
    state_d    = state_q;
    data_out_d = data_out_q;
    overrun_d  = overrun_q;
    word_ready = 1'b0;

    if (clk_read) begin
      if (sample == cand_q) begin
        if (cnt_q < STABLE_CNT) cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cand_d = sample;
        cnt_d  = CNT_W'(1);
      end
    end

    // Decided on next-state values so a word is reported on the very edge it qualifies.
    word_ready = (cnt_d == STABLE_CNT) && (cand_d != data_out_q);

    case (state_q)
      IDLE: begin
        if (word_ready) begin
          data_out_d = cand_d;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (word_ready) overrun_d = 1'b1;
        if (data_ack)   state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge n_clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cand_q     <= '0;
      cnt_q      <= '0;
      data_out_q <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      data_out_q <= data_out_d;
      overrun_q  <= overrun_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = (state_q == HOLD);
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_input_sampler.sv
// Directed bench for input_sampler with a sample-history reference model checked every cycle.
module tb_input_sampler;

  localparam int W  = 8;
  localparam int SC = 4;

  logic         n_clock = 1'b0;
  logic         reset;
  logic         clk_read;
  logic [W-1:0] raw_in;
  logic         data_ack;
  logic [W-1:0] data_out;
  logic         data_valid;
  logic         overrun;

  input_sampler #(.WIDTH(W), .STABLE_COUNT(SC)) dut (
    .n_clock    (n_clock),
    .reset      (reset),
    .clk_read   (clk_read),
    .raw_in     (raw_in),
    .data_ack   (data_ack),
    .data_out   (data_out),
    .data_valid (data_valid),
    .overrun    (overrun)
  );

  always #5 n_clock = ~n_clock;

  int checks = 0;
  int errors = 0;
  int phase  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the word is accepted once the last SC ticked samples agree.
  logic [W-1:0] hist[$];
  logic [W-1:0] m_out, m_smp, m_s1, m_s2;
  logic         m_valid, m_ovr, m_stable, m_ready;
  bit           model_ok = 0;

  always @(posedge n_clock) begin
    if (reset) begin
      hist.delete();
      m_out = '0; m_valid = 0; m_ovr = 0; m_s1 = '0; m_s2 = '0;
      model_ok = 1;
    end else if (model_ok) begin
`ifdef INPUT_SAMPLER_SYNC_EN
      m_smp = m_s2; m_s2 = m_s1; m_s1 = raw_in;
`else
      m_smp = raw_in;
`endif
      if (clk_read) begin
        hist.push_back(m_smp);
        if (hist.size() > SC) void'(hist.pop_front());
      end
      m_stable = (hist.size() == SC);
      m_ready  = 0;
      if (m_stable) begin
        for (int i = 0; i < SC; i++) if (hist[i] != hist[SC-1]) m_stable = 0;
        m_ready = m_stable && (hist[SC-1] != m_out);
      end
      if (!m_valid) begin
        if (m_ready) begin m_out = hist[SC-1]; m_valid = 1; end
      end else begin
        if (m_ready) m_ovr = 1;
        if (data_ack) m_valid = 0;
      end
    end
  end

  always @(negedge n_clock) begin
    if (model_ok) begin
      chk("model_data_out", 32'(data_out), 32'(m_out));
      chk("model_data_valid", 32'(data_valid), 32'(m_valid));
      chk("model_overrun", 32'(overrun), 32'(m_ovr));
    end
  end

  task automatic step();
    @(negedge n_clock);
    phase    = (phase + 1) % 10;
    clk_read = (phase == 0);
  endtask

  // Runs through the next tick edge and returns one cycle later.
  task automatic wait_tick();
    int n = 0;
    while (!clk_read && n < 12) begin step(); n++; end
    if (!clk_read) begin
      checks++; errors++;
      $display("FAIL tick_timeout actual=no_tick required=tick_within_12");
    end
    step();
  endtask

  localparam int S2_N = 5;
  logic [W-1:0] s2_seq [S2_N] = '{8'hA5, 8'h00, 8'hA5, 8'hA5, 8'hA5};

  initial begin
    reset = 1; raw_in = '0; data_ack = 0; clk_read = 0;
    step(); step();
    reset = 0;
    chk("rst_data_out", 32'(data_out), 32'h0);
    chk("rst_data_valid", 32'(data_valid), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);

    // ack without valid, raw 0 equals reset data_out
    data_ack = 1; raw_in = 8'h00;
    wait_tick(); wait_tick();
    chk("s5_valid", 32'(data_valid), 32'h0);
    chk("s5_out", 32'(data_out), 32'h0);
    data_ack = 0;

    // interrupted run: valid only on the 4th consecutive A5
    foreach (s2_seq[i]) begin
      raw_in = s2_seq[i];
      wait_tick();
      chk("s2_no_valid", 32'(data_valid), 32'h0);
      chk("s2_out_held", 32'(data_out), 32'h0);
    end
    wait_tick();
    chk("s2_valid", 32'(data_valid), 32'h1);
    chk("s2_out", 32'(data_out), 32'hA5);

    // new stable word while A5 unacked -> overrun, then reported after ack
    raw_in = 8'h3C;
    for (int i = 0; i < 3; i++) wait_tick();
    chk("s3_ovr_pre", 32'(overrun), 32'h0);
    wait_tick();
    chk("s3_out_held", 32'(data_out), 32'hA5);
    chk("s3_valid_held", 32'(data_valid), 32'h1);
    chk("s3_overrun", 32'(overrun), 32'h1);
    data_ack = 1;
    step();
    data_ack = 0;
    chk("s3_ack_drop", 32'(data_valid), 32'h0);
    step();
    chk("s3_revalid", 32'(data_valid), 32'h1);
    chk("s3_out_new", 32'(data_out), 32'h3C);
    chk("s3_ovr_sticky", 32'(overrun), 32'h1);

    // reset in HOLD
    reset = 1;
    step();
    reset = 0;
    chk("s4_out", 32'(data_out), 32'h0);
    chk("s4_valid", 32'(data_valid), 32'h0);
    chk("s4_overrun", 32'(overrun), 32'h0);

    // basic qualify: A5 held for SC ticks
    raw_in = 8'hA5;
    for (int i = 0; i < SC - 1; i++) begin
      wait_tick();
      chk("s1_no_valid", 32'(data_valid), 32'h0);
      chk("s1_out_held", 32'(data_out), 32'h0);
    end
    wait_tick();
    chk("s1_valid", 32'(data_valid), 32'h1);
    chk("s1_out", 32'(data_out), 32'hA5);
    data_ack = 1;
    step();
    data_ack = 0;
    chk("s1_ack", 32'(data_valid), 32'h0);
    wait_tick(); wait_tick();
    chk("s1_same_word_quiet", 32'(data_valid), 32'h0);

`ifdef INPUT_SAMPLER_SYNC_EN
    // raw changes one cycle before a tick: that tick still sees A5
    while (phase != 9) step();
    raw_in = 8'h5A;
    for (int i = 0; i < SC; i++) wait_tick();
    chk("s6_late_no_valid", 32'(data_valid), 32'h0);
    wait_tick();
    chk("s6_valid", 32'(data_valid), 32'h1);
    chk("s6_out", 32'(data_out), 32'h5A);
`endif

    step(); step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
